// File: rtl/tt_sweep.sv
// Exhaustive truth-table sweeper: drives all 2^N vectors (binary or Gray order),
// holds each HOLD cycles, samples dut_y on the last hold cycle and tallies mismatches.
module tt_sweep #(
    parameter int              N        = 3,
    parameter int              HOLD     = 10,
    parameter int              MODE     = 0,
    parameter logic [2**N-1:0] EXPECTED = 8'hE8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dut_y,
    output logic [N-1:0] vec_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_err,
    output logic         err_seen
);

    localparam int IW = N + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(2**N - 1);
    localparam logic [IW-1:0] MAX_ERR  = IW'(2**N);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IW-1:0] err_count_q, err_count_d;
    logic [N-1:0]  first_err_q, first_err_d;
    logic          err_seen_q, err_seen_d;
    logic [N-1:0]  sel_idx;
    logic [N-1:0]  code;

    // DONE keeps showing the final vector even though idx has already advanced to 2^N.
    always_comb begin
        sel_idx = (state_q == DONE) ? {N{1'b1}} : idx_q[N-1:0];
        code    = (MODE == 1) ? (sel_idx ^ (sel_idx >> 1)) : sel_idx;
        vec_out = (state_q == IDLE) ? '0 : code;
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_cnt_d  = hold_cnt_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = APPLY;
                    idx_d       = '0;
                    hold_cnt_d  = '0;
                    err_count_d = '0;
                    first_err_d = '0;
                    err_seen_d  = 1'b0;
                end
            end
            APPLY: begin
                if (hold_cnt_q == LAST_HOLD) begin
                    if (dut_y != EXPECTED[vec_out]) begin
                        if (err_count_q != MAX_ERR) err_count_d = err_count_q + IW'(1);
                        if (!err_seen_q) begin
                            first_err_d = vec_out;
                            err_seen_d  = 1'b1;
                        end
                    end
                    hold_cnt_d = '0;
                    idx_d      = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) state_d = DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_cnt_q  <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_cnt_q  <= hold_cnt_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
        end
    end

    assign busy      = (state_q == APPLY);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_count_q == '0);
    assign err_count = err_count_q;
    assign first_err = first_err_q;
    assign err_seen  = err_seen_q;

endmodule
